// File: rtl/pixel_sink_pkg.sv
// Shared definitions for the pixel_sink capture port: register offsets,
// STATUS bit positions, bus handshake states and the checksum adder.
package pixel_sink_pkg;

    localparam logic [2:0] PS_DATA   = 3'd0;
    localparam logic [2:0] PS_STATUS = 3'd1;
    localparam logic [2:0] PS_CTRL   = 3'd2;
    localparam logic [2:0] PS_TOTAL  = 3'd3;
    localparam logic [2:0] PS_CKSUM  = 3'd4;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_UNDERRUN  = 3;
    localparam int ST_COUNT_LSB = 16;

    typedef enum logic {
        PS_IDLE = 1'b0,
        PS_RESP = 1'b1
    } ps_bus_state_e;

    // Modulo-255 add; a is always below 255, so one conditional subtract suffices.
    function automatic logic [7:0] add_mod255(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        logic [8:0] res;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 9'd255) begin
            res = sum - 9'd255;
        end else begin
            res = sum;
        end
        return res[7:0];
    endfunction

endpackage

// File: rtl/pixel_sink_fifo.sv
// Synchronous FIFO for pixel_sink: natural-wrap pointers, registered count,
// combinational read of the head entry, flush returns it to empty.
module pixel_sink_fifo
    import pixel_sink_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_FULL);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !reset) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/pixel_sink.sv
// Memory-mapped capture port: buffers the engine's pixel stream for CPU reads.
// Optional CHECKSUM register at 0x10 when PIXEL_SINK_CHECKSUM_EN is defined.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] ADDR_BASE = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    ps_bus_state_e r_state, w_state_next;
    logic          r_en, r_underrun, r_overflow;
    logic [31:0]   r_total, r_rdata, w_rdata_next, w_status, w_cksum;
    logic [7:0]    w_dout;
    logic [CW-1:0] w_count;
    logic          w_full, w_empty, w_sel, w_accept, w_is_wr, w_ctrl_wr;
    logic          w_clear, w_data_rd, w_pop, w_push, w_unused;
    logic [2:0]    w_off;

    assign w_sel     = iomem_valid && (iomem_addr[31:8] == ADDR_BASE[31:8]);
    assign w_accept  = (r_state == PS_IDLE) && w_sel;
    assign w_is_wr   = |iomem_wstrb;
    assign w_off     = iomem_addr[4:2];
    assign w_ctrl_wr = w_accept && w_is_wr && (w_off == PS_CTRL) && iomem_wstrb[0];
    assign w_clear   = w_ctrl_wr && iomem_wdata[1];
    assign w_data_rd = w_accept && !w_is_wr && (w_off == PS_DATA);
    assign w_pop     = w_data_rd && !w_empty;
    // A pixel handshaken alongside a clear is dropped rather than stored.
    assign w_push    = pix_valid && pix_ready && r_en && !w_clear;
    assign w_unused  = ^{iomem_wdata[31:3], iomem_addr[7:5], iomem_addr[1:0]};

    assign pix_ready   = !r_en || !w_full;
    assign iomem_ready = (r_state == PS_RESP);
    assign iomem_rdata = r_rdata;

    pixel_sink_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (pix_data),
        .pop   (w_pop),
        .flush (w_clear),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

`ifdef PIXEL_SINK_CHECKSUM_EN
    logic [7:0] r_s1, r_s2, w_s1_next;
    assign w_s1_next = add_mod255(r_s1, pix_data);
    assign w_cksum   = {16'h0000, r_s2, r_s1};

    // Fletcher-style running sums over pixels stored in the FIFO.
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_s1 <= 8'h00;
            r_s2 <= 8'h00;
        end else if (w_push) begin
            r_s1 <= w_s1_next;
            r_s2 <= add_mod255(r_s2, w_s1_next);
        end
    end
`else
    assign w_cksum = 32'h0000_0000;
`endif

    // Bus handshake: one response cycle per accepted access, no decode during it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PS_IDLE: begin
                if (w_sel) w_state_next = PS_RESP;
                else       w_state_next = PS_IDLE;
            end
            PS_RESP: w_state_next = PS_IDLE;
            default: w_state_next = PS_IDLE;
        endcase
    end

    // Read-data mux, sampled from pre-edge state of the accepting cycle.
    always_comb begin
        w_status                         = 32'h0000_0000;
        w_status[ST_COUNT_LSB +: CW]     = w_count;
        w_status[ST_UNDERRUN]            = r_underrun;
        w_status[ST_OVERFLOW]            = r_overflow;
        w_status[ST_FULL]                = w_full;
        w_status[ST_EMPTY]               = w_empty;
        w_rdata_next                     = 32'h0000_0000;
        case (w_off)
            PS_DATA:   w_rdata_next = w_empty ? 32'h0000_0000 : {23'h000000, 1'b1, w_dout};
            PS_STATUS: w_rdata_next = w_status;
            PS_CTRL:   w_rdata_next = {31'h0000_0000, r_en};
            PS_TOTAL:  w_rdata_next = r_total;
            PS_CKSUM:  w_rdata_next = w_cksum;
            default:   w_rdata_next = 32'h0000_0000;
        endcase
    end

    // Control/status registers and registered bus response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= PS_IDLE;
            r_en       <= 1'b0;
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
            r_total    <= 32'h0000_0000;
            r_rdata    <= 32'h0000_0000;
        end else begin
            r_state <= w_state_next;
            r_rdata <= (w_accept && !w_is_wr) ? w_rdata_next : 32'h0000_0000;
            if (w_ctrl_wr) r_en <= iomem_wdata[0];
            // Sticky clear first so a coincident new event still latches.
            if (w_ctrl_wr && iomem_wdata[2]) begin
                r_underrun <= 1'b0;
                r_overflow <= 1'b0;
            end
            if (w_data_rd && w_empty) r_underrun <= 1'b1;
            if (pix_valid && !pix_ready && r_en) r_overflow <= 1'b1;
            if (w_clear)     r_total <= 32'h0000_0000;
            else if (w_push) r_total <= r_total + 32'd1;
        end
    end

endmodule

// File: tb/tb_pixel_sink.sv
// Scoreboard bench for pixel_sink: a queue-based model predicts bus responses
// and pix_ready; a separate monitor compares each iomem_ready response.
`timescale 1ns/1ps
module tb_pixel_sink;
    import pixel_sink_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        reset, pix_valid, pix_ready, iomem_valid, iomem_ready;
    logic [7:0]  pix_data;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;

    always #5 clk = ~clk;

    pixel_sink #(.DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata)
    );

    typedef struct {
        bit          chk;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fails  = 0;

    // Reference model state
    logic [7:0]  m_q[$];
    bit          m_en, m_under, m_over, m_busy;
    logic [31:0] m_total;
    int          m_s1, m_s2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] off);
        int n;
        n = m_q.size();
        case (off)
            3'd0:    return (n > 0) ? {23'h0, 1'b1, m_q[0]} : 32'h0;
            3'd1:    return {16'(n), 12'h000, m_under, m_over, (n == DEPTH), (n == 0)};
            3'd2:    return {31'h0, m_en};
            3'd3:    return m_total;
`ifdef PIXEL_SINK_CHECKSUM_EN
            3'd4:    return {16'h0000, 8'(m_s2), 8'(m_s1)};
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Response monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (iomem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_ready: got iomem_ready=1 expected no response at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk) check(mon_e.name, iomem_rdata, mon_e.val);
            end
        end
    end

    // One clock cycle: drive inputs, predict, step the model across the edge.
    task automatic cyc(input bit rst, input bit pv, input logic [7:0] pd, input bit bv,
                       input logic [3:0] ws, input logic [31:0] addr, input logic [31:0] wd);
        bit         mready, acc, rd, ctrl_wr, clr, pop, push;
        logic [2:0] off;
        exp_t       e;
        reset = rst; pix_valid = pv; pix_data = pd; iomem_valid = bv;
        iomem_wstrb = ws; iomem_addr = addr; iomem_wdata = wd;
        mready  = !m_en || (m_q.size() < DEPTH);
        if (!rst) check("pix_ready", 32'(pix_ready), 32'(mready));
        off     = addr[4:2];
        acc     = bv && !m_busy && (addr[31:8] == BASE[31:8]);
        rd      = acc && (ws == 4'h0);
        ctrl_wr = acc && ws[0] && (off == 3'd2);
        clr     = ctrl_wr && wd[1];
        pop     = rd && (off == 3'd0) && (m_q.size() > 0);
        push    = pv && mready && m_en && !clr;
        if (!rst && acc) begin
            e.chk  = rd;
            e.val  = m_read(off);
            e.name = $sformatf("read_off%0d", off);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            m_q.delete(); m_en = 0; m_under = 0; m_over = 0; m_busy = 0;
            m_total = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            if (ctrl_wr && wd[2]) begin m_under = 0; m_over = 0; end
            if (rd && off == 3'd0 && m_q.size() == 0) m_under = 1;
            if (pv && !mready && m_en) m_over = 1;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back(pd);
                m_total = m_total + 32'd1;
                m_s1 = (m_s1 + int'(pd)) % 255;
                m_s2 = (m_s2 + m_s1) % 255;
            end
            if (clr) begin m_q.delete(); m_total = 0; m_s1 = 0; m_s2 = 0; end
            if (ctrl_wr) m_en = wd[0];
            m_busy = acc;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 8'h00, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic pix(input logic [7:0] d);
        cyc(0, 1, d, 0, 4'h0, 32'h0, 32'h0);
    endtask

    // Bus access with valid held through the response cycle.
    task automatic bus(input bit we, input logic [2:0] off, input logic [31:0] wd,
                       input bit pv, input logic [7:0] pd);
        logic [31:0] a;
        logic [3:0]  ws;
        a  = BASE + {27'h0, off, 2'b00};
        ws = we ? 4'hF : 4'h0;
        cyc(0, pv, pd, 1, ws, a, wd);
        cyc(0, pv, pd, 1, ws, a, wd);
    endtask

    task automatic rd(input logic [2:0] off);
        bus(0, off, 32'h0, 0, 8'h00);
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] wd);
        bus(1, off, wd, 0, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pix_valid = 1'b0; pix_data = 8'h00; iomem_valid = 1'b0;
        iomem_wstrb = 4'h0; iomem_addr = 32'h0; iomem_wdata = 32'h0;
        m_en = 0; m_under = 0; m_over = 0; m_busy = 0; m_total = 0; m_s1 = 0; m_s2 = 0;
        @(negedge clk);
        repeat (3) cyc(1, 0, 8'h00, 0, 4'h0, 32'h0, 32'h0);
        check("reset_pix_ready",   32'(pix_ready),   32'd1);
        check("reset_iomem_ready", 32'(iomem_ready), 32'd0);
        check("reset_iomem_rdata", iomem_rdata,      32'd0);
        rd(PS_STATUS); rd(PS_TOTAL); rd(PS_CTRL);

        // Basic capture and underrun
        wr(PS_CTRL, 32'h1);
        pix(8'h11); pix(8'h22); pix(8'h33);
        repeat (4) rd(PS_DATA);
        rd(PS_STATUS);

        // Fill past capacity
        wr(PS_CTRL, 32'h7);
        for (int i = 0; i < 20; i++) pix(8'($urandom));
        check("full_pix_ready", 32'(pix_ready), 32'd0);
        rd(PS_STATUS); rd(PS_TOTAL);

        // Pop while full with a pixel waiting, then drain
        bus(0, PS_DATA, 32'h0, 1, 8'hA5);
        pix(8'h5A);
        for (int i = 0; i < 17; i++) rd(PS_DATA);
        rd(PS_STATUS);

        // Clear with pixels queued
        for (int i = 0; i < 5; i++) pix(8'($urandom));
        wr(PS_CTRL, 32'h3);
        rd(PS_STATUS); rd(PS_TOTAL); rd(PS_CTRL);

        // Byte strobes, ignored writes, unmapped and foreign addresses
        cyc(0, 0, 8'h00, 1, 4'b0010, BASE + 32'h8, 32'h0);
        cyc(0, 0, 8'h00, 1, 4'b0010, BASE + 32'h8, 32'h0);
        rd(PS_CTRL);
        pix(8'h44);
        wr(PS_TOTAL, 32'hFFFF_FFFF); wr(PS_DATA, 32'h0); wr(PS_STATUS, 32'hFFFF_FFFF);
        rd(PS_TOTAL); rd(PS_STATUS); rd(3'd5); rd(3'd7);
        cyc(0, 0, 8'h00, 1, 4'h0, 32'h0400_0004, 32'h0);
        cyc(0, 0, 8'h00, 1, 4'h0, 32'h0400_0004, 32'h0);

        // Checksum
        wr(PS_CTRL, 32'h3);
        pix(8'h01); pix(8'h02);
        rd(PS_CKSUM);

        // Disabled: pixels discarded
        wr(PS_CTRL, 32'h0);
        for (int i = 0; i < 4; i++) pix(8'($urandom));
        rd(PS_STATUS); rd(PS_TOTAL);

        // Randomized traffic
        wr(PS_CTRL, 32'h1);
        for (int i = 0; i < 500; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                cyc(0, ($urandom_range(0, 3) != 0), 8'($urandom), 0, 4'h0, 32'h0, 32'h0);
            end else if (sel <= 7) begin
                bus(0, 3'($urandom_range(0, 5)), 32'h0, $urandom_range(0, 1) == 1, 8'($urandom));
            end else if (sel == 8) begin
                bus(1, PS_CTRL, {29'h0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                                 ($urandom_range(0, 4) != 0)}, $urandom_range(0, 1) == 1, 8'($urandom));
            end else begin
                bus(0, PS_DATA, 32'h0, $urandom_range(0, 1) == 1, 8'($urandom));
            end
        end
        rd(PS_STATUS); rd(PS_TOTAL); rd(PS_CKSUM);

        // Reset on the cycle a read is sampled: no response
        wr(PS_CTRL, 32'h1);
        pix(8'h77); pix(8'h78);
        cyc(1, 1, 8'h79, 1, 4'h0, BASE, 32'h0);
        idle(3);
        rd(PS_STATUS); rd(PS_CTRL); rd(PS_TOTAL);

        idle(3);
        check("outstanding_responses", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pixel_sink.md
# pixel_sink

Memory-mapped capture port at the output end of the image-processing engine. It accepts the engine's processed pixel stream through a valid/ready handshake and buffers it in a synchronous FIFO. The CPU drains the FIFO over the SoC iomem bus. It replaces testbench-side snooping of the engine's output, so firmware can read processed pixels directly.

## Interface
- `DEPTH`, 16: FIFO depth in pixels; power of two, range 4..256.
- `ADDR_BASE`, 32'h0300_0000: block base address; the decoder compares `iomem_addr[31:8]`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `pix_valid`  in  1  the engine presents a pixel.
- `pix_data`  in  8  pixel value.
- `pix_ready`  out  1  the sink accepts the pixel this cycle.
- `iomem_valid`  in  1  bus request.
- `iomem_ready`  out  1  bus completion pulse.
- `iomem_wstrb`  in  4  byte write strobes; all zero means read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  read data; valid while `iomem_ready` is high.

## Operation
- A pixel is accepted on a cycle with `pix_valid && pix_ready`.
- `pix_ready` = `!en || !full`. It is derived only from registered state.
- When `en`=0, pixels are accepted and discarded: no FIFO write and no count increment.
- Register map (offset = `addr[4:2]`):
  - 0x00 DATA (read): pops one pixel and returns `{23'b0, 1'b1, pixel}`. A read when empty returns 0, does not pop, and sets sticky `underrun`.
  - 0x04 STATUS (read): `{count[15:0], 12'b0, underrun, overflow, full, empty}`. `overflow` sets when `pix_valid && !pix_ready && en`.
  - 0x08 CTRL (r/w): bit0 `en`, bit1 `clear` (write-1 pulse, self-clearing, reads 0), bit2 write-1 clears both sticky flags.
  - 0x0C TOTAL (read): 32-bit count of pixels accepted into the FIFO; wraps at 2^32.
  - Other offsets: reads return 0, writes are ignored.
- `clear`: flushes the FIFO (pointers and count to 0) and zeroes TOTAL. A pixel presented in the same cycle is dropped. `en` is unaffected.
- Writes to DATA, STATUS or TOTAL are ignored but still complete with `iomem_ready`.
- Byte strobes: CTRL updates only when `wstrb[0]` is set.

## Timing
- Reset values: `pix_ready`=1, `iomem_ready`=0, `iomem_rdata`=0, `en`=0, FIFO empty, all sticky flags 0, TOTAL=0.
- Bus access:
  - Latency is one cycle. `iomem_ready` pulses high in the cycle after a selected `iomem_valid` is sampled, for exactly one cycle.
  - No new access is decoded while `iomem_ready` is high, even if `iomem_valid` stays high.
  - Bus states: IDLE→RESP on a selected valid; RESP→IDLE unconditionally.
- DATA pop is committed in the IDLE→RESP cycle. The popped data is registered into `iomem_rdata`.
- Simultaneous push and pop:
  - Not full and not empty: count is unchanged and both operations succeed.
  - Full: the pop succeeds, but the push is refused because `pix_ready` was already 0.
  - Empty: the pop returns "empty" and the push lands. There is no fall-through.
- `count` and `full`/`empty` update on the edge following the push or pop. STATUS reflects them from the next access.
- Reset asserted mid-transaction aborts it. `iomem_ready` is not issued for the aborted access.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` is `$clog2(DEPTH)+1` bits.

## Configuration
- `PIXEL_SINK_CHECKSUM_EN` defined:
  - Adds register 0x10 CHECKSUM: a 16-bit Fletcher-style sum updated per accepted pixel.
    - `s1 = (s1 + pix) mod 255`
    - `s2 = (s2 + s1) mod 255`
    - Read value: `{16'b0, s2, s1}`.
  - Both sums are zeroed by reset and by `clear`.
- Not defined: offset 0x10 reads 0 and no checksum logic is built.

## Structure
- Shared package `pixel_sink_pkg`:
  - register offset constants (`PS_DATA`, `PS_STATUS`, `PS_CTRL`, `PS_TOTAL`, `PS_CKSUM`);
  - STATUS bit positions;
  - bus state enum (`PS_IDLE`, `PS_RESP`).
- One sub-module, `pixel_sink_fifo`: a synchronous FIFO with parameters DEPTH and width 8, ports push/pop/flush, and outputs dout/count/full/empty.
- Bus decode, registers and checksum live in the top.

## Test plan
- Reset, then read STATUS → 0x0000_0001 (empty). `pix_ready`=1. TOTAL=0.
- CTRL=1; push 0x11, 0x22, 0x33; read DATA three times → 0x111, 0x122, 0x133. A fourth read → 0, and STATUS `underrun`=1.
- DEPTH=16, `en`=1, no reads, `pix_valid` held for 20 cycles → `pix_ready` falls after 16 accepts, STATUS `full`=1, `overflow`=1, TOTAL=16. Draining 16 reads returns the values in order.
- Full FIFO: issue a DATA read while `pix_valid` is high → the pop is served, the push is refused that cycle, and the push is accepted the cycle after `full` clears.
- Write CTRL=0x3 with 5 pixels queued → STATUS `empty`=1 and TOTAL=0 on the next read, and `en` stays 1.
- With `PIXEL_SINK_CHECKSUM_EN`: push 0x01, 0x02 → CHECKSUM=0x0000_0403. Without the macro, offset 0x10 → 0.
